// File: rtl/context_switch_ctrl.sv
// Round-robin context-switch sequencer: owns the process table (valid + saved PC per slot),
// allocates slots for the loader and halts/drains/saves/loads the CPU on each switch.
module context_switch_ctrl #(
  parameter  int MAX_PROC = 8,
  parameter  int QUANTUM  = 20,
  parameter  int PC_W     = 32,
  localparam int ID_W     = $clog2(MAX_PROC)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            create_req,
  input  logic [PC_W-1:0] create_pc,
  output logic            create_ack,
  output logic [ID_W-1:0] create_id,
  output logic            create_err,
  input  logic            exit_req,
  input  logic [PC_W-1:0] pc_in,
  input  logic            cpu_idle,
  output logic            cpu_halt,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_out,
  output logic [ID_W-1:0] current_id,
  output logic            current_valid
);

  localparam int              CNT_W    = $clog2(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, SAVE, SELECT, LOAD} state_t;

  state_t              state, state_next;
  logic [MAX_PROC-1:0] valid;
  logic [PC_W-1:0]     pc_mem [MAX_PROC];
  logic [CNT_W-1:0]    counter;
  logic                exiting;

  logic                alloc_found;
  logic [ID_W-1:0]     alloc_id;
  logic                sel_found;
  logic [ID_W-1:0]     sel_id, sel_base, sel_idx;
  logic [MAX_PROC-1:0] cur_onehot;
  logic                others_valid;
  logic                quantum_expired;
  logic                do_alloc;

  // Lowest-index free slot; the descending loop lets the lowest hit win.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    alloc_found = 1'b0;
    alloc_id    = '0;
    for (int i = MAX_PROC - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc_found = 1'b1;
        alloc_id    = ID_W'(i);
      end
    end
  end

  // Round-robin search from current_id+1, wrapping, current_id last. With no process
  // running (coming from IDLE) the search starts at slot 0.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_idx   = '0;
    sel_base  = current_valid ? current_id + ID_W'(1) : '0;
    for (int k = 0; k < MAX_PROC; k++) begin
      sel_idx = sel_base + ID_W'(k);
      if (!sel_found && valid[sel_idx]) begin
        sel_found = 1'b1;
        sel_id    = sel_idx;
      end
    end
  end

  assign cur_onehot      = MAX_PROC'(1) << current_id;
  assign others_valid    = |(valid & ~cur_onehot);
  assign quantum_expired = enable && (counter == CNT_LAST);
  assign do_alloc        = create_req && alloc_found;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|valid) state_next = SELECT;
      RUN:     if (exit_req || (quantum_expired && others_valid)) state_next = DRAIN;
      DRAIN:   if (cpu_idle) state_next = SAVE;
      SAVE:    state_next = SELECT;
      SELECT:  state_next = sel_found ? LOAD : IDLE;
      LOAD:    state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_halt = (state != RUN);
    pc_load  = (state == LOAD);
  end

  // Slice counter, exit flag and the incoming-process registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter       <= '0;
      exiting       <= 1'b0;
      current_id    <= '0;
      current_valid <= 1'b0;
      pc_out        <= '0;
    end else begin
      case (state)
        RUN: begin
          if (exit_req) begin
            counter <= '0;
            exiting <= 1'b1;
          end else if (quantum_expired) begin
            counter <= '0;
            exiting <= 1'b0;
          end else if (enable) begin
            counter <= counter + CNT_W'(1);
          end
        end
        SELECT: begin
          if (sel_found) begin
            current_id    <= sel_id;
            current_valid <= 1'b1;
            pc_out        <= pc_mem[sel_id];
            counter       <= '0;
          end else begin
            current_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The allocator sees pre-clear valid bits, so an exiting slot is never handed out
  // in the same cycle it is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else begin
      if (do_alloc) valid[alloc_id] <= 1'b1;
      if (state == SAVE && exiting) valid[current_id] <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      create_ack <= 1'b0;
      create_err <= 1'b0;
      create_id  <= '0;
    end else begin
      create_ack <= do_alloc;
      create_err <= create_req && !alloc_found;
      if (do_alloc) create_id <= alloc_id;
    end
  end

  // NOTE: the PC table is deliberately not reset; a slot's PC is only read after a create wrote it.
  always_ff @(posedge clock) begin
    if (do_alloc) pc_mem[alloc_id] <= create_pc;
    if (state == SAVE && !exiting) pc_mem[current_id] <= pc_in;
  end

endmodule
